// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and helpers for the UART transmit arbiter slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int DATA_BITS_DEFAULT = 8;

    typedef logic [DATA_BITS_DEFAULT-1:0] uart_byte_t;

    // Width that can hold an index below n; never returns zero.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin finder: first set request strictly
//            after the pointer, with wrap-around.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    // Scanning from the farthest offset down lets the nearest hit win.
    always_comb begin
        int                w_pos;
        logic [IDX_W-1:0]  w_sel;
        w_pos   = 0;
        w_sel   = '0;
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_pos = (int'(i_ptr) + k) % NUM_REQ;
            w_sel = IDX_W'(w_pos);
            if (i_req[w_sel]) begin
                o_idx   = w_sel;
                o_found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Message-granular round-robin arbiter sharing one UART TX byte
//            port between NUM_REQ requesters, with a registered output stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ      = 4,
    parameter int  DATA_BITS    = 8,
    parameter int  HOLD_TIMEOUT = 1024,
    localparam int ID_W         = safe_clog2(NUM_REQ),
    localparam int CNT_W        = safe_clog2(HOLD_TIMEOUT + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [ID_W-1:0]              grant_id,
    output logic                         locked,
    output logic                         timeout_pulse
);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [ID_W-1:0]      r_grant;
    logic [ID_W-1:0]      w_grant_nxt;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      w_ptr_nxt;
    logic [CNT_W-1:0]     r_idle;
    logic [CNT_W-1:0]     w_idle_nxt;
    logic                 w_timeout;
    logic [DATA_BITS-1:0] r_tx_data;
    logic                 r_tx_valid;
    logic                 r_timeout;

    logic [ID_W-1:0]      w_pick_idx;
    logic                 w_pick_found;
    logic                 w_gnt_valid;
    logic                 w_gnt_last;
    logic [DATA_BITS-1:0] w_gnt_data;
    logic                 w_buf_ready;
    logic                 w_accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_gnt_valid = req_valid[r_grant];
    assign w_gnt_last  = req_last[r_grant];
    assign w_gnt_data  = req_data[int'(r_grant)*DATA_BITS +: DATA_BITS];
    // Single-entry buffer: refill in the same cycle the transmitter drains it.
    assign w_buf_ready = !r_tx_valid || tx_ready;
    assign w_accept    = (r_state == ARB_LOCKED) && w_gnt_valid && w_buf_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_idle_nxt  = r_idle;
        w_timeout   = 1'b0;
        req_ready   = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = ARB_LOCKED;
                    w_grant_nxt = w_pick_idx;
                    w_idle_nxt  = '0;
                end
            end
            ARB_LOCKED: begin
                req_ready[r_grant] = w_buf_ready;
                if (w_gnt_valid) begin
                    w_idle_nxt = '0;
                    if (w_accept && w_gnt_last) begin
                        w_state_nxt = ARB_IDLE;
                        w_ptr_nxt   = r_grant;
                    end
                end else if (HOLD_TIMEOUT > 0) begin
                    // Release on the cycle the idle count would reach the limit.
                    if (r_idle == CNT_W'(HOLD_TIMEOUT - 1)) begin
                        w_state_nxt = ARB_IDLE;
                        w_ptr_nxt   = r_grant;
                        w_idle_nxt  = '0;
                        w_timeout   = 1'b1;
                    end else if (r_idle != '1) begin
                        w_idle_nxt = r_idle + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ARB_IDLE;
            r_grant   <= '0;
            r_ptr     <= ID_W'(NUM_REQ - 1);
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_ptr     <= w_ptr_nxt;
            r_idle    <= w_idle_nxt;
            r_timeout <= w_timeout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else if (w_accept) begin
            r_tx_data  <= w_gnt_data;
            r_tx_valid <= 1'b1;
        end else if (tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign tx_data       = r_tx_data;
    assign tx_valid      = r_tx_valid;
    assign grant_id      = r_grant;
    assign locked        = (r_state == ARB_LOCKED);
    assign timeout_pulse = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            against a message-level round-robin scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int HT = 16;

    logic            clk;
    logic            rst_n;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [DW-1:0]   tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [1:0]      grant_id;
    logic            locked;
    logic            timeout_pulse;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .DATA_BITS    (DW),
        .HOLD_TIMEOUT (HT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .grant_id      (grant_id),
        .locked        (locked),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester-side message queues and the expected transmit stream.
    uart_byte_t q_data [NR][$];
    bit         q_last [NR][$];
    bit         mute [NR];
    bit         stop_after [NR];
    uart_byte_t exp_tx [$];
    int         cur_owner;
    int         sb_ptr;
    int         idle_cnt;
    bit         exp_pulse;
    int         pulses_seen;
    int         tx_mode;
    bit         prev_hold;
    logic [DW-1:0] prev_data;
    int         tests;
    int         fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [NR-1:0] valid_set();
        bit [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = (q_data[i].size() > 0) && !mute[i];
        return v;
    endfunction

    function automatic int rr_next(input int ptr, input bit [NR-1:0] v);
        for (int k = 1; k <= NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            q_data[i].delete();
            q_last[i].delete();
            mute[i]       = 1'b0;
            stop_after[i] = 1'b0;
        end
        exp_tx.delete();
        cur_owner = -1;
        sb_ptr    = NR - 1;
        idle_cnt  = 0;
        exp_pulse = 1'b0;
        prev_hold = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (q_data[i].size() > 0 && !mute[i]) begin
                req_valid[i]         = 1'b1;
                req_data[i*DW +: DW] = q_data[i][0];
                req_last[i]          = q_last[i][0];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[i*DW +: DW] = '0;
                req_last[i]          = 1'b0;
            end
        end
        tx_ready = (tx_mode == 0) ? 1'b1 : (tx_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic sample();
        bit [NR-1:0] vs;
        int          own;
        uart_byte_t  b;
        bit          l;
        vs = valid_set();
        if (timeout_pulse || exp_pulse) chk("timeout_pulse", 32'(timeout_pulse), 32'(exp_pulse));
        if (timeout_pulse) pulses_seen++;
        exp_pulse = 1'b0;
        if (prev_hold) begin
            chk("tx_hold_valid", 32'(tx_valid), 32'd1);
            chk("tx_hold_data", 32'(tx_data), 32'(prev_data));
        end
        if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) chk("tx_unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
            else chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
        if (req_ready != '0) begin
            chk("req_ready_count", 32'($countones(req_ready)), 32'd1);
            if (cur_owner >= 0) chk("req_ready_owner", 32'(req_ready), 32'(1 << cur_owner));
        end
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                if (cur_owner < 0) begin
                    own = rr_next(sb_ptr, vs);
                    chk("msg_owner", 32'(i), 32'(own));
                    cur_owner = i;
                end else if (i != cur_owner) begin
                    chk("interleave", 32'(i), 32'(cur_owner));
                end
                b = q_data[i].pop_front();
                l = q_last[i].pop_front();
                exp_tx.push_back(b);
                if (stop_after[i]) begin
                    mute[i]       = 1'b1;
                    stop_after[i] = 1'b0;
                end
                if (l) begin
                    sb_ptr    = i;
                    cur_owner = -1;
                end
            end
        end
        if (cur_owner < 0 || vs[cur_owner]) begin
            idle_cnt = 0;
        end else begin
            idle_cnt++;
            if (idle_cnt == HT) begin
                exp_pulse = 1'b1;
                sb_ptr    = cur_owner;
                cur_owner = -1;
                idle_cnt  = 0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic push_msg(input int r, input int n);
        for (int k = 0; k < n; k++) begin
            q_data[r].push_back(uart_byte_t'($urandom_range(0, 255)));
            q_last[r].push_back(k == n - 1);
        end
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_tx.size() > 0) || (cur_owner >= 0) || tx_valid;
        for (int i = 0; i < NR; i++) b = b || (q_data[i].size() > 0);
        return b;
    endfunction

    task automatic wait_drain(input int maxc);
        int k;
        k = 0;
        while (busy() && k < maxc) begin
            cycle();
            k++;
        end
        chk("drain_done", 32'(busy()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string phase);
        chk({phase, "_tx_valid"}, 32'(tx_valid), 32'd0);
        chk({phase, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({phase, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({phase, "_locked"}, 32'(locked), 32'd0);
        chk({phase, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({phase, "_timeout"}, 32'(timeout_pulse), 32'd0);
    endtask

    initial begin
        int p0;
        tests       = 0;
        fails       = 0;
        pulses_seen = 0;
        tx_mode     = 0;
        prev_data   = '0;
        req_data    = '0;
        req_valid   = '0;
        req_last    = '0;
        tx_ready    = 1'b1;
        rst_n       = 1'b0;
        model_clear();
        drive();
        #22;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // "HI\n" from requester 2 with an always-ready transmitter.
        q_data[2].push_back(8'h48); q_last[2].push_back(1'b0);
        q_data[2].push_back(8'h49); q_last[2].push_back(1'b0);
        q_data[2].push_back(8'h0A); q_last[2].push_back(1'b1);
        drive();
        cycle();
        chk("hi_locked", 32'(locked), 32'd1);
        chk("hi_grant", 32'(grant_id), 32'd2);
        cycle();
        chk("hi_tx0_valid", 32'(tx_valid), 32'd1);
        chk("hi_tx0", 32'(tx_data), 32'h48);
        cycle();
        chk("hi_tx1", 32'(tx_data), 32'h49);
        cycle();
        chk("hi_tx2", 32'(tx_data), 32'h0A);
        chk("hi_unlocked", 32'(locked), 32'd0);
        wait_drain(50);

        // Requesters 0 and 1 together from reset, then again, then 3 alone.
        rst_n = 1'b0;
        model_clear();
        drive();
        #2;
        rst_n = 1'b1;
        push_msg(0, 3);
        push_msg(1, 3);
        drive();
        wait_drain(100);
        push_msg(0, 2);
        push_msg(1, 2);
        drive();
        cycle();
        chk("rr_wrap_grant", 32'(grant_id), 32'd0);
        wait_drain(100);
        push_msg(3, 2);
        drive();
        cycle();
        chk("rr_r3_grant", 32'(grant_id), 32'd3);
        wait_drain(100);

        // Transmitter stall for 50 cycles in mid-message.
        p0 = pulses_seen;
        push_msg(1, 8);
        drive();
        repeat (4) cycle();
        tx_mode = 2;
        drive();
        repeat (50) cycle();
        chk("stall_tx_valid", 32'(tx_valid), 32'd1);
        chk("stall_req_ready", 32'(req_ready), 32'd0);
        chk("stall_no_timeout", 32'(pulses_seen), 32'(p0));
        tx_mode = 0;
        drive();
        wait_drain(100);

        // Granted requester goes silent after one byte; requester 3 waits.
        p0 = pulses_seen;
        q_data[1].push_back(8'hA1); q_last[1].push_back(1'b0);
        q_data[1].push_back(8'hA2); q_last[1].push_back(1'b1);
        stop_after[1] = 1'b1;
        drive();
        cycle();
        chk("to_grant", 32'(grant_id), 32'd1);
        cycle();
        push_msg(3, 2);
        drive();
        repeat (24) cycle();
        chk("to_pulse_count", 32'(pulses_seen - p0), 32'd1);
        mute[1] = 1'b0;
        drive();
        wait_drain(100);

        // Reset while a byte is stuck in the output buffer.
        tx_mode = 2;
        push_msg(2, 5);
        drive();
        repeat (4) cycle();
        chk("pre_reset_tx_valid", 32'(tx_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_clear();
        tx_mode = 0;
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_msg(0, 2);
        push_msg(2, 2);
        drive();
        cycle();
        chk("post_reset_grant", 32'(grant_id), 32'd0);
        wait_drain(100);

        // Randomized traffic with a randomly stalling transmitter.
        tx_mode = 1;
        for (int round = 0; round < 3; round++) begin
            for (int r = 0; r < NR; r++) begin
                for (int m = 0; m < int'($urandom_range(0, 3)); m++) push_msg(r, int'($urandom_range(1, 4)));
            end
            drive();
            wait_drain(3000);
        end
        chk("final_exp_empty", 32'(exp_tx.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte port between NUM_REQ requesters, e.g. a console, a debug dumper and a status reporter.
- Arbitrates round-robin at message granularity. A grant is held until the requester's last byte, so messages never interleave on the wire.
- Sits between the requesters and the transmitter's valid/ready byte input, with one registered output stage.

Parameters:
- NUM_REQ, 4, number of requesters; 2..16.
- DATA_BITS, 8, byte width; must match the transmitter.
- HOLD_TIMEOUT, 1024, idle cycles inside a locked message before the grant is force-released; 0 disables the timeout.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_data  input  NUM_REQ*DATA_BITS  requester bytes; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
- req_valid  input  NUM_REQ  byte valid, one bit per requester.
- req_last  input  NUM_REQ  marks the final byte of a message; qualified by req_valid.
- req_ready  output  NUM_REQ  byte accepted when req_valid[i] & req_ready[i].
- tx_data  output  DATA_BITS  byte to the transmitter.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  transmitter accepts the byte.
- grant_id  output  $clog2(NUM_REQ)  current owner; meaningful only while locked.
- locked  output  1  a message is in progress.
- timeout_pulse  output  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tx_valid=0, tx_data=0, req_ready=0, locked=0, grant_id=0, timeout_pulse=0.
  - Round-robin pointer=NUM_REQ-1, so requester 0 has first priority.
  - Idle counter=0.
- Handshakes are valid/ready, transfer on valid & ready.
  - Requesters must hold data, valid and last stable until accepted.
  - The block holds tx_data and tx_valid stable while tx_valid & !tx_ready.
- FSM state IDLE:
  - req_ready=0.
  - If any req_valid is high, grant the first set bit searching upward from pointer+1 with wrap-around.
  - Register grant_id, set locked=1, go to LOCKED. This takes one cycle; no byte moves in that cycle.
- FSM state LOCKED:
  - Only req_ready[grant_id] may be 1. Its value is !tx_valid | tx_ready (single-entry output buffer, full throughput).
  - An accepted byte appears on tx_data with tx_valid=1 on the next cycle (latency 1).
  - Accepting a byte with req_last=1: go to IDLE, set pointer=grant_id, locked=0 on the next cycle.
  - The output buffer drains independently of FSM state. A last byte may still be pending on tx while the next arbitration runs.
  - Back-to-back messages from different requesters: one idle cycle on the input side, no gap on tx if the transmitter is slow.
- Timeout (HOLD_TIMEOUT>0):
  - The idle counter increments each LOCKED cycle with req_valid[grant_id]=0.
  - It clears on any cycle where req_valid[grant_id]=1.
  - On reaching HOLD_TIMEOUT: go to IDLE, pointer=grant_id, timeout_pulse=1 for one cycle, counter=0.
  - A requester stalled waiting on tx_ready never times out.
- Simultaneous events:
  - A requester dropping req_valid while granted is legal (idle gap); the grant is held.
  - req_last on a non-granted requester is ignored.
  - Timeout and an accepted byte cannot coincide, because acceptance implies valid.
- Other boundaries:
  - NUM_REQ=1 degenerates to a pass-through plus one arbitration cycle per message.
  - Pointer wrap-around: from NUM_REQ-1, the search starts at 0.
  - Reset mid-message: the pending output byte is discarded and tx_valid drops immediately. The transmitter must tolerate an abandoned byte.
- Widths:
  - The idle counter is $clog2(HOLD_TIMEOUT+1) bits and saturates.
  - The pointer is $clog2(NUM_REQ) bits, minimum 1.

Decomposition:
- A uart_pkg package holds:
  - the FSM state enum (ARB_IDLE, ARB_LOCKED);
  - a typedef for the byte type, sized by DATA_BITS default 8;
  - a shared clog2-safe width helper constant function.
- Sub-module rr_pick: purely combinational round-robin finder over a NUM_REQ request vector and a pointer, returning the index and a found flag. It is reusable by other shared peripherals.

Test Plan:
- Single requester 2 sends "HI\n" (last on '\n'), tx_ready always 1 -> grant_id=2 one cycle after the first valid; tx shows 0x48, 0x49, 0x0A on consecutive cycles; locked drops after 0x0A is accepted.
- Requesters 0 and 1 each hold a 3-byte message simultaneously from reset -> tx carries 0's three bytes in order, then 1's three bytes; no interleave; pointer=1 afterwards.
- Then requesters 0 and 1 request again -> 0 granted first (search starts at pointer+1=2, wraps to 0); a later request from 3 only is granted in its turn.
- tx_ready held 0 for 50 cycles mid-message -> tx_data stable, req_ready[grant_id]=0 while the buffer is full, no timeout_pulse; the stream resumes with no byte loss or duplication.
- HOLD_TIMEOUT=16: granted requester sends 1 byte without last, then goes silent -> timeout_pulse exactly 16 idle cycles later; the next pending requester is granted on the following arbitration.
- rst_n asserted while tx_valid=1 mid-message -> all outputs at reset values in the same cycle; after release, requester 0 is granted first.
